// File: rtl/conv_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The power-of-ten helper backs the elaboration-time sizing check of the top.
package conv_bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    localparam int N_BITS_PADRAO    = 8;
    localparam int N_DIGITOS_PADRAO = 3;
    localparam int LARGURA_DIGITO   = 4;

    function automatic longint unsigned pot10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/SomaMais3_Condicional.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// The 4-bit result width drops the carry, which cannot occur for legal digits.
module SomaMais3_Condicional (
    input  logic [3:0] entrada,
    output logic [3:0] saida
);

    // Conditional add-3 on one digit
    always_comb begin
        if (entrada >= 4'd5) begin
            saida = entrada + 4'd3;
        end else begin
            saida = entrada;
        end
    end

endmodule

// File: rtl/conversor_bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// The result register only updates on completion, so bcd never shows partial sums.
module conversor_bin_bcd_seq
    import conv_bcd_pkg::*;
#(
    parameter int N_BITS    = N_BITS_PADRAO,
    parameter int N_DIGITOS = N_DIGITOS_PADRAO
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                inicio,
    input  logic [N_BITS-1:0]                   entrada,
    output logic                                ocupado,
    output logic                                pronto,
    output logic [LARGURA_DIGITO*N_DIGITOS-1:0] bcd
);

    localparam int LB = LARGURA_DIGITO * N_DIGITOS;
    localparam int CW = $clog2(N_BITS + 1);

    if ((N_BITS < 2) || (N_BITS > 16)) begin : g_n_bits_invalido
        $error("conversor_bin_bcd_seq: N_BITS must be within 2..16");
    end
    if (pot10(N_DIGITOS) <= ((64'd1 << N_BITS) - 64'd1)) begin : g_digitos_insuficientes
        $error("conversor_bin_bcd_seq: N_DIGITOS too small for N_BITS");
    end

    estado_t            estado_r, proximo_s;
    logic [N_BITS-1:0]  binario_r;
    logic [LB-1:0]      scratch_r, ajustado_s, bcd_r;
    logic [CW-1:0]      contador_r;
    logic [LB+N_BITS-1:0] deslocado_s;
    logic               ocupado_r, pronto_r;
    logic               ocupado_prox_s, pronto_prox_s;
    logic               aceita_s, termina_s;

    for (genvar g = 0; g < N_DIGITOS; g++) begin : g_digito
        SomaMais3_Condicional u_soma (
            .entrada (scratch_r[g*LARGURA_DIGITO +: LARGURA_DIGITO]),
            .saida   (ajustado_s[g*LARGURA_DIGITO +: LARGURA_DIGITO])
        );
    end

    // Corrected digits and binary shift together, binary MSB entering the units digit
    assign deslocado_s = {ajustado_s, binario_r} << 32'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= proximo_s;
        end
    end

    // Next-state logic; output flags are derived from the next state and registered
    always_comb begin
        proximo_s = estado_r;
        aceita_s  = 1'b0;
        termina_s = 1'b0;
        case (estado_r)
            OCIOSO: begin
                if (inicio) begin
                    proximo_s = CONVERTE;
                    aceita_s  = 1'b1;
                end else begin
                    proximo_s = OCIOSO;
                end
            end
            CONVERTE: begin
                if (contador_r == CW'(1)) begin
                    proximo_s = FIM;
                    termina_s = 1'b1;
                end else begin
                    proximo_s = CONVERTE;
                end
            end
            FIM:     proximo_s = OCIOSO;
            default: proximo_s = OCIOSO;
        endcase
        ocupado_prox_s = (proximo_s == CONVERTE) || (proximo_s == FIM);
        pronto_prox_s  = (proximo_s == FIM);
    end

    // Datapath: capture, shift, count down, and latch the finished result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binario_r  <= '0;
            scratch_r  <= '0;
            contador_r <= '0;
            bcd_r      <= '0;
            ocupado_r  <= 1'b0;
            pronto_r   <= 1'b0;
        end else begin
            ocupado_r <= ocupado_prox_s;
            pronto_r  <= pronto_prox_s;
            if (aceita_s) begin
                binario_r  <= entrada;
                scratch_r  <= '0;
                contador_r <= CW'(N_BITS);
            end else if (estado_r == CONVERTE) begin
                scratch_r  <= deslocado_s[LB+N_BITS-1:N_BITS];
                binario_r  <= deslocado_s[N_BITS-1:0];
                contador_r <= contador_r - CW'(1);
                if (termina_s) begin
                    bcd_r <= deslocado_s[LB+N_BITS-1:N_BITS];
                end
            end
        end
    end

    assign ocupado = ocupado_r;
    assign pronto  = pronto_r;
    assign bcd     = bcd_r;

endmodule

// File: doc/conversor_bin_bcd_seq.md
CONVERSOR_BIN_BCD_SEQ -- requirements
Module: conversor_bin_bcd_seq

Interface
REQ-001 Parameter N_BITS, default 8, binary input width (2..16).
REQ-002 Parameter N_DIGITOS, default 3, number of BCD output digits; 10^N_DIGITOS SHALL exceed 2^N_BITS-1, checked at elaboration.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 inicio  input  1  start request, sampled on rising clk.
REQ-006 entrada  input  N_BITS  unsigned binary value to convert, sampled with inicio.
REQ-007 ocupado  output  1  high while a conversion is in progress or completing.
REQ-008 pronto  output  1  one-cycle pulse, result valid.
REQ-009 bcd  output  4*N_DIGITOS  packed BCD result, digit 0 (units) in bits [3:0].

Function
REQ-010 FSM states: OCIOSO, CONVERTE, FIM; reset state OCIOSO.
REQ-011 OCIOSO with inicio=1 at an edge: capture entrada into binary shift register, clear BCD scratch register, load counter with N_BITS, go to CONVERTE.
REQ-012 inicio SHALL be ignored in CONVERTE and FIM; no queueing, no effect on the running conversion.
REQ-013 Each CONVERTE edge: every scratch digit passes through the conditional add-3 (digit >= 5 -> digit+3, else unchanged), then scratch||binary shifts left one bit, binary MSB entering scratch bit 0; counter decrements.
REQ-014 Add-3 SHALL be applied before the shift in the same cycle; the add-3 carry-out is discarded (cannot occur for digits <= 9).
REQ-015 On the edge where the counter reaches 0 (the N_BITS-th shift): load bcd from the shifted scratch, go to FIM.
REQ-016 FIM lasts exactly one cycle, then OCIOSO unconditionally.
REQ-017 pronto = 1 only in FIM; ocupado = 1 in CONVERTE and FIM.
REQ-018 Latency: inicio accepted at edge k -> pronto high in the cycle after edge k+N_BITS; next inicio accepted earliest at edge k+N_BITS+2.
REQ-019 bcd SHALL hold the last completed result until the next FIM load; it SHALL NOT show intermediate scratch values.
REQ-020 entrada changes after acceptance SHALL NOT affect the result.
REQ-021 entrada = 0 SHALL still run the full N_BITS cycles and produce all-zero bcd.
REQ-022 Every produced digit SHALL be in 0..9.

Reset
REQ-023 rst=1 forces, without clock: state OCIOSO, ocupado=0, pronto=0, bcd=0, scratch, shift and counter registers = 0.
REQ-024 Reset during CONVERTE or FIM aborts the conversion; no pronto pulse for it; bcd = 0.
REQ-025 After rst deasserts, an inicio at the first rising edge SHALL be accepted.

Structure
REQ-026 Shared package conv_bcd_pkg: FSM state type (OCIOSO, CONVERTE, FIM), default N_BITS/N_DIGITOS constants, BCD digit width constant 4.
REQ-027 Per-digit add-3 SHALL reuse existing SomaMais3_Condicional, one instance per digit via generate; no new sub-module.
REQ-028 Counter width SHALL be ceil(log2(N_BITS+1)) bits.

Verification
REQ-029 Defaults, entrada=8'd255, inicio 1 cycle -> ocupado next cycle, pronto after 8 shifts, bcd=12'h255.
REQ-030 entrada=8'd0 -> bcd=12'h000 with same latency; entrada=8'd99 -> 12'h099; entrada=8'd100 -> 12'h100.
REQ-031 Start 8'd200, reassert inicio with 8'd17 mid-conversion -> result 12'h200, single pronto pulse.
REQ-032 Start 8'd123, assert rst at 4th CONVERTE cycle -> ocupado/pronto/bcd 0 immediately, no pronto; restart 8'd45 -> 12'h045.
REQ-033 Back-to-back starts 8'd7 then 8'd128 with inicio held high -> 12'h007 then 12'h128, second accepted exactly 2 edges after first pronto edge.
REQ-034 Exhaustive 0..255 sweep against reference model -> all digits match and are <= 9.
